// File: rtl/ifetch_stage.sv
// Purpose : instruction fetch; owns the PC, addresses a sync-read ROM, fills IF/ID {instr, pc+4, valid}.
// Latency : ROM word lands in IF/ID one edge after its address is issued; taken redirect costs one bubble.
// Backpr. : stall freezes PC and IF/ID and ignores redirects; no other flow control.
//
// Ports
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   stall                     hazard-unit hold of PC and IF/ID
//   ctl_valid                 qualifies the ID-stage control inputs below
//   Jr/Jmp/Jal/Branch/nBranch decoder control-transfer flags (one-hot), Zero = rs==rt
//   Imm_extended, jaddr       ID immediate and jump field
//   jr_target, id_pc4         forwarded rs for Jr, pc+4 of the ID instruction
//   imem_addr / imem_rdata    ROM word address (from pc_next) / data for pc_q one edge later
//   if_instr/if_pc4/if_valid  IF/ID pipeline register (if_instr = 0 when invalid)
//   redirect                  a control transfer is being taken this cycle
//
// Build option: define IFETCH_PERF_EN to add perf_fetch / perf_squash / perf_stall counters.

module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               ctl_valid,
    input  logic               Jr,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Zero,
    input  logic [31:0]        Imm_extended,
    input  logic [25:0]        jaddr,
    input  logic [31:0]        jr_target,
    input  logic [31:0]        id_pc4,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc4,
    output logic               if_valid,
    output logic               redirect
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_squash,
    output logic [31:0]        perf_stall
`endif
);

    // PRIME covers the single edge after reset release during which the ROM
    // latches the first word; nothing valid can enter IF/ID before then.
    typedef enum logic {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] target;
    logic        xfer_req;
    logic        take;
    logic        run;

    // Jr targets are forced word-aligned, so the two low bits are never used.
    logic        unused_jr_lsbs;
    assign unused_jr_lsbs = ^jr_target[1:0];

    assign run      = (state == S_RUN);
    assign pc_plus4 = pc_q + 32'd4;

    // Control-transfer decision for the instruction sitting in ID.
    assign xfer_req = Jr | Jmp | Jal | (Branch & Zero) | (nBranch & ~Zero);
    assign take     = ctl_valid & ~stall & xfer_req;
    assign redirect = take & run;

    // Target select; Jr beats Jmp/Jal beats branch should the flags ever overlap.
    always_comb begin
        target = id_pc4 + (Imm_extended << 2);
        if (Jr) begin
            target = {jr_target[31:2], 2'b00};
        end else if (Jmp | Jal) begin
            target = {id_pc4[31:28], jaddr, 2'b00};
        end
    end

    // In PRIME the PC holds so the ROM keeps reading RESET_PC; this also makes
    // a stall or a stray control input during PRIME harmless.
    always_comb begin
        pc_next = pc_plus4;
        if (!run || stall) begin
            pc_next = pc_q;
        end else if (take) begin
            pc_next = target;
        end
    end

    // The ROM is addressed with pc_next so that its registered output lines up
    // with pc_q on the following cycle.
    assign imem_addr = pc_next[IMEM_AW+1:2];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_PRIME;
            pc_q     <= RESET_PC;
            if_instr <= 32'h0;
            if_pc4   <= 32'h0;
            if_valid <= 1'b0;
        end else begin
            case (state)
                S_PRIME: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    pc_q <= pc_next;
                    if (!stall) begin
                        if (take) begin
                            // No delay slot: the word fetched alongside the
                            // transfer is the wrong path and becomes a nop.
                            // if_pc4 is left as is; if_valid qualifies it.
                            if_instr <= 32'h0;
                            if_valid <= 1'b0;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc4   <= pc_plus4;
                            if_valid <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    // Event counters, RUN edges only, free-running modulo 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch  <= 32'h0;
            perf_squash <= 32'h0;
            perf_stall  <= 32'h0;
        end else if (run) begin
            if (stall) begin
                perf_stall <= perf_stall + 32'd1;
            end else if (take) begin
                perf_squash <= perf_squash + 32'd1;
            end else begin
                perf_fetch <= perf_fetch + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          AW       = 14;
    localparam int K_NONE = 0, K_JR = 1, K_JMP = 2, K_JAL = 3, K_BEQ = 4, K_BNE = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          stall, ctl_valid, Jr, Jmp, Jal, Branch, nBranch, Zero;
    logic [31:0]   Imm_extended, jr_target, id_pc4, imem_rdata;
    logic [25:0]   jaddr;
    logic [AW-1:0] imem_addr;
    logic [31:0]   if_instr, if_pc4;
    logic          if_valid, redirect;
`ifdef IFETCH_PERF_EN
    logic [31:0]   perf_fetch, perf_squash, perf_stall;
`endif

    ifetch_stage #(.RESET_PC(RESET_PC), .IMEM_AW(AW)) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .ctl_valid(ctl_valid),
        .Jr(Jr), .Jmp(Jmp), .Jal(Jal), .Branch(Branch), .nBranch(nBranch), .Zero(Zero),
        .Imm_extended(Imm_extended), .jaddr(jaddr), .jr_target(jr_target), .id_pc4(id_pc4),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_instr(if_instr), .if_pc4(if_pc4), .if_valid(if_valid), .redirect(redirect)
`ifdef IFETCH_PERF_EN
        , .perf_fetch(perf_fetch), .perf_squash(perf_squash), .perf_stall(perf_stall)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous-read ROM.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clock) imem_rdata <= mem[imem_addr];

    // Stimulus for the current cycle (what the decoder presents).
    int          s_kind;
    bit          s_cv, s_zero, s_stall;
    logic [31:0] s_imm, s_jrt, s_idpc4;
    logic [25:0] s_ja;

    // Reference model: architectural view of the fetch stage.
    bit          m_prime;
    logic [31:0] m_pc, m_word, m_instr, m_pc4;
    bit          m_valid;
    logic [31:0] m_fetch, m_squash, m_stall;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        ctl_valid    = s_cv;
        stall        = s_stall;
        Jr           = (s_kind == K_JR);
        Jmp          = (s_kind == K_JMP);
        Jal          = (s_kind == K_JAL);
        Branch       = (s_kind == K_BEQ);
        nBranch      = (s_kind == K_BNE);
        Zero         = s_zero;
        Imm_extended = s_imm;
        jaddr        = s_ja;
        jr_target    = s_jrt;
        id_pc4       = s_idpc4;
    endtask

    task automatic none();
        s_cv = 0; s_kind = K_NONE; s_stall = 0; s_zero = 0;
        s_imm = 0; s_ja = 0; s_jrt = 0; s_idpc4 = 0;
    endtask

    function automatic bit m_take();
        if (!s_cv || s_stall) return 1'b0;
        case (s_kind)
            K_JR, K_JMP, K_JAL: return 1'b1;
            K_BEQ:              return s_zero;
            K_BNE:              return !s_zero;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] ja32;
        ja32 = {6'b0, s_ja};
        case (s_kind)
            K_JR:         return s_jrt & 32'hFFFF_FFFC;
            K_JMP, K_JAL: return (s_idpc4 & 32'hF000_0000) | (ja32 * 4);
            default:      return s_idpc4 + s_imm * 4;
        endcase
    endfunction

    function automatic logic [31:0] m_next();
        if (m_prime || s_stall) return m_pc;
        if (m_take()) return m_target();
        return m_pc + 32'd4;
    endfunction

    task automatic model_reset();
        m_prime = 1; m_pc = RESET_PC; m_word = 0;
        m_instr = 0; m_pc4 = 0; m_valid = 0;
        m_fetch = 0; m_squash = 0; m_stall = 0;
    endtask

    task automatic model_edge();
        logic [31:0] nxt;
        bit tk;
        nxt = m_next();
        tk  = m_take();
        if (!m_prime) begin
            if (s_stall) m_stall++;
            else if (tk) begin m_valid = 0; m_instr = 0; m_squash++; end
            else begin m_instr = m_word; m_pc4 = m_pc + 32'd4; m_valid = 1; m_fetch++; end
        end
        m_pc    = nxt;
        m_word  = mem[(nxt >> 2) % (1 << AW)];
        m_prime = 0;
    endtask

    task automatic check_comb();
        chk("redirect", {31'b0, redirect}, {31'b0, m_take() && !m_prime});
        chk("imem_addr", 32'(imem_addr), (m_next() >> 2) % (1 << AW));
    endtask

    task automatic check_regs();
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        chk("if_instr", if_instr, m_instr);
        if (m_valid) chk("if_pc4", if_pc4, m_pc4);
`ifdef IFETCH_PERF_EN
        chk("perf_fetch", perf_fetch, m_fetch);
        chk("perf_squash", perf_squash, m_squash);
        chk("perf_stall", perf_stall, m_stall);
`endif
    endtask

    // Called at a negedge: present stimulus, check combinational outputs.
    task automatic cyc_a();
        apply();
        #1;
        check_comb();
    endtask

    // Clock edge, model update, check registered outputs at the negedge.
    task automatic cyc_b();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_regs();
    endtask

    task automatic cycle();
        cyc_a();
        cyc_b();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        check_regs();
        check_comb();
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[0] = 32'hA000_000A; mem[1] = 32'hB000_000B;
        mem[2] = 32'hC000_000C; mem[3] = 32'hD000_000D;
        none();
        apply();
        #1;
        do_reset();

        // Sequential fetch from reset.
        cycle();
        chk("s1_prime_valid", {31'b0, if_valid}, 32'h0);
        cycle(); chk("s1_instrA", if_instr, 32'hA000_000A); chk("s1_pc4_A", if_pc4, 32'h4);
        cycle(); chk("s1_instrB", if_instr, 32'hB000_000B); chk("s1_pc4_B", if_pc4, 32'h8);
        cycle(); chk("s1_instrC", if_instr, 32'hC000_000C); chk("s1_pc4_C", if_pc4, 32'hC);
        cycle(); chk("s1_instrD", if_instr, 32'hD000_000D); chk("s1_pc4_D", if_pc4, 32'h10);
        cycle(); chk("s1_pc4_E", if_pc4, 32'h14);

        // beq at 0x10 taken, imm 3 -> 0x20.
        s_cv = 1; s_kind = K_BEQ; s_zero = 1; s_imm = 32'h3; s_idpc4 = 32'h14;
        cyc_a();
        chk("s2_redirect", {31'b0, redirect}, 32'h1);
        chk("s2_addr", 32'(imem_addr), 32'h8);
        cyc_b();
        chk("s2_squash", {31'b0, if_valid}, 32'h0);
`ifdef IFETCH_PERF_EN
        chk("s2_perf_squash", perf_squash, 32'h1);
        chk("s2_perf_fetch", perf_fetch, 32'h5);
`endif
        none();
        cycle();
        chk("s2_tgt_instr", if_instr, mem[8]);
        chk("s2_tgt_pc4", if_pc4, 32'h24);

        // bne with Zero=1 falls through; then beq with imm -1.
        s_cv = 1; s_kind = K_BNE; s_zero = 1; s_imm = 32'h5; s_idpc4 = 32'h24;
        cyc_a();
        chk("s3_bne_redirect", {31'b0, redirect}, 32'h0);
        chk("s3_bne_addr", 32'(imem_addr), 32'hA);
        cyc_b();
        chk("s3_bne_pc4", if_pc4, 32'h28);
        s_kind = K_BEQ; s_imm = 32'hFFFF_FFFF; s_idpc4 = 32'h28;
        cyc_a();
        chk("s3_beqm1_addr", 32'(imem_addr), 32'h9);
        cyc_b();
        none();
        cycle();
        chk("s3_beqm1_pc4", if_pc4, 32'h28);

        // Jal keeps id_pc4[31:28]; Jr drops the low bits.
        s_cv = 1; s_kind = K_JAL; s_ja = 26'h40; s_idpc4 = 32'h1000_0008;
        cyc_a();
        chk("s4_jal_addr", 32'(imem_addr), 32'h40);
        cyc_b();
        none();
        cycle();
        chk("s4_jal_pc4", if_pc4, 32'h1000_0104);
        chk("s4_jal_instr", if_instr, mem[32'h40]);
        s_cv = 1; s_kind = K_JR; s_jrt = 32'h0000_0203;
        cyc_a();
        chk("s4_jr_addr", 32'(imem_addr), 32'h80);
        cyc_b();
        none();
        cycle();
        chk("s4_jr_pc4", if_pc4, 32'h204);

        // Stall with Jmp held for three cycles, then released.
        s_cv = 1; s_kind = K_JMP; s_ja = 26'h100; s_idpc4 = 32'h0000_0300; s_stall = 1;
        for (int i = 0; i < 3; i++) begin
            cyc_a();
            chk("s5_stall_redirect", {31'b0, redirect}, 32'h0);
            chk("s5_stall_addr", 32'(imem_addr), 32'h81);
            cyc_b();
            chk("s5_frozen_pc4", if_pc4, 32'h204);
            chk("s5_frozen_instr", if_instr, mem[32'h80]);
        end
        s_stall = 0;
        cyc_a();
        chk("s5_jmp_redirect", {31'b0, redirect}, 32'h1);
        chk("s5_jmp_addr", 32'(imem_addr), 32'h100);
        cyc_b();
        none();
        cycle();
        chk("s5_jmp_pc4", if_pc4, 32'h404);
`ifdef IFETCH_PERF_EN
        chk("s5_perf_stall", perf_stall, 32'h3);
`endif

        // PC wrap at the top of the address space.
        s_cv = 1; s_kind = K_JR; s_jrt = 32'hFFFF_FFFF;
        cycle();
        none();
        cyc_a();
        chk("s7_wrap_addr", 32'(imem_addr), 32'h0);
        cyc_b();
        chk("s7_wrap_pc4", if_pc4, 32'h0);

        // Reset mid-stream, then refetch from RESET_PC.
        cycle();
        do_reset();
`ifdef IFETCH_PERF_EN
        chk("s6_perf_clear", perf_fetch | perf_squash | perf_stall, 32'h0);
`endif
        cycle();
        cycle();
        chk("s6_refetch", if_instr, 32'hA000_000A);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                s_stall = ($urandom_range(0, 4) == 0);
                s_cv    = ($urandom_range(0, 1) == 1);
                s_kind  = int'($urandom_range(0, 5));
                s_zero  = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 1) == 1) begin
                    s_imm = $urandom;
                    s_imm = {{16{s_imm[15]}}, s_imm[15:0]};
                end else begin
                    s_imm = $urandom;
                end
                s_ja    = 26'($urandom);
                s_jrt   = $urandom;
                s_idpc4 = $urandom & 32'hFFFF_FFFC;
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
